// File: rtl/arm_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : arm_control_unit
//  Purpose  : Single-cycle ARM-subset decoder, condition check and NZCV flag
//             register. Define ARM_CTRL_PERF_EN to add exec/squash counters.
//  Revision : 1.0  initial release
// ============================================================================
module arm_control_unit #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Instr_i,
    input  logic [3:0]         ALUFlags_i,
    output logic [1:0]         RegSrc_o,
    output logic               RegWrite_o,
    output logic [1:0]         ImmSrc_o,
    output logic               ALUSrc_o,
    output logic [3:0]         ALUControl_o,
    output logic               MemtoReg_o,
    output logic               MemWrite_o,
    output logic               PCSrc_o,
    output logic [3:0]         Flags_o,
`ifdef ARM_CTRL_PERF_EN
    output logic [COUNT_W-1:0] ExecCount_o,
    output logic [COUNT_W-1:0] SquashCount_o,
`endif
    output logic               Undef_o
);

    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_ORR = 4'd3;
    localparam logic [3:0] c_ALU_EOR = 4'd4;
    localparam logic [3:0] c_ALU_MOV = 4'd5;

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;

    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [3:0] w_rd;
    logic [3:0] w_cond;

    assign w_op   = Instr_i[27:26];
    assign w_cmd  = Instr_i[24:21];
    assign w_s    = Instr_i[20];
    assign w_rd   = Instr_i[15:12];
    assign w_cond = Instr_i[31:28];

    logic [1:0] w_reg_src;
    logic       w_reg_w_req;
    logic [1:0] w_imm_src;
    logic       w_alu_src;
    logic [3:0] w_alu_ctl;
    logic       w_mem_to_reg;
    logic       w_mem_w_req;
    logic       w_branch;
    logic       w_undef;
    logic       w_flag_w_req;
    logic       w_flag_arith;
    logic       w_pc_req;

    always_comb begin
        w_reg_src    = 2'b00;
        w_reg_w_req  = 1'b0;
        w_imm_src    = 2'b00;
        w_alu_src    = 1'b0;
        w_alu_ctl    = c_ALU_ADD;
        w_mem_to_reg = 1'b0;
        w_mem_w_req  = 1'b0;
        w_branch     = 1'b0;
        w_undef      = 1'b0;
        w_flag_w_req = 1'b0;
        w_flag_arith = 1'b0;
        case (w_op)
            c_OP_DP: begin
                w_alu_src    = Instr_i[25];
                w_reg_w_req  = 1'b1;
                w_flag_w_req = w_s;
                case (w_cmd)
                    4'b0000: w_alu_ctl = c_ALU_AND;
                    4'b0001: w_alu_ctl = c_ALU_EOR;
                    4'b0010: begin
                        w_alu_ctl    = c_ALU_SUB;
                        w_flag_arith = 1'b1;
                    end
                    4'b0100: begin
                        w_alu_ctl    = c_ALU_ADD;
                        w_flag_arith = 1'b1;
                    end
                    // TST/CMP only make sense when they set flags
                    4'b1000: begin
                        w_alu_ctl   = c_ALU_AND;
                        w_reg_w_req = 1'b0;
                        w_undef     = ~w_s;
                    end
                    4'b1010: begin
                        w_alu_ctl    = c_ALU_SUB;
                        w_flag_arith = 1'b1;
                        w_reg_w_req  = 1'b0;
                        w_undef      = ~w_s;
                    end
                    4'b1100: w_alu_ctl = c_ALU_ORR;
                    4'b1101: w_alu_ctl = c_ALU_MOV;
                    default: begin
                        w_reg_w_req = 1'b0;
                        w_undef     = 1'b1;
                    end
                endcase
            end
            c_OP_MEM: begin
                w_alu_src = 1'b1;
                w_imm_src = 2'b01;
                w_alu_ctl = Instr_i[23] ? c_ALU_ADD : c_ALU_SUB;
                if (Instr_i[20]) begin
                    w_reg_w_req  = 1'b1;
                    w_mem_to_reg = 1'b1;
                end else begin
                    w_mem_w_req  = 1'b1;
                    w_reg_src[1] = 1'b1;
                end
            end
            c_OP_BR: begin
                w_imm_src    = 2'b10;
                w_alu_src    = 1'b1;
                w_alu_ctl    = c_ALU_ADD;
                w_reg_src[0] = 1'b1;
                w_branch     = 1'b1;
                w_undef      = Instr_i[24];
            end
            default: w_undef = 1'b1;
        endcase
    end

    assign w_pc_req = w_branch | (w_reg_w_req & (w_rd == 4'hF));

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_cond_ex;
    logic       w_exec;

    assign {w_n, w_z, w_c, w_v} = flags_q;

    // Condition reads only the registered flags: no same-cycle bypass.
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'h0:    w_cond_ex = w_z;
            4'h1:    w_cond_ex = ~w_z;
            4'h2:    w_cond_ex = w_c;
            4'h3:    w_cond_ex = ~w_c;
            4'h4:    w_cond_ex = w_n;
            4'h5:    w_cond_ex = ~w_n;
            4'h6:    w_cond_ex = w_v;
            4'h7:    w_cond_ex = ~w_v;
            4'h8:    w_cond_ex = w_c & ~w_z;
            4'h9:    w_cond_ex = ~w_c | w_z;
            4'hA:    w_cond_ex = (w_n == w_v);
            4'hB:    w_cond_ex = (w_n != w_v);
            4'hC:    w_cond_ex = ~w_z & (w_n == w_v);
            4'hD:    w_cond_ex = w_z | (w_n != w_v);
            4'hE:    w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_exec = w_cond_ex & ~w_undef;

    assign RegSrc_o     = w_reg_src;
    assign ImmSrc_o     = w_imm_src;
    assign ALUSrc_o     = w_alu_src;
    assign ALUControl_o = w_alu_ctl;
    assign MemtoReg_o   = w_mem_to_reg;
    assign RegWrite_o   = w_reg_w_req & w_exec;
    assign MemWrite_o   = w_mem_w_req & w_exec;
    assign PCSrc_o      = w_pc_req & w_exec;
    assign Undef_o      = w_undef;
    assign Flags_o      = flags_q;

    // Logical ops leave C and V untouched.
    always_comb begin
        flags_d = flags_q;
        if (w_exec && w_flag_w_req) begin
            flags_d[3:2] = ALUFlags_i[3:2];
            if (w_flag_arith) begin
                flags_d[1:0] = ALUFlags_i[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef ARM_CTRL_PERF_EN
    logic [COUNT_W-1:0] exec_cnt_q;
    logic [COUNT_W-1:0] squash_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else if (w_exec) begin
            exec_cnt_q   <= exec_cnt_q + 1'b1;
        end else begin
            squash_cnt_q <= squash_cnt_q + 1'b1;
        end
    end

    assign ExecCount_o   = exec_cnt_q;
    assign SquashCount_o = squash_cnt_q;
`else
    logic [COUNT_W-1:0] unused_count_w;
    assign unused_count_w = '0;
`endif

    logic unused_instr_w;
    assign unused_instr_w = ^Instr_i[11:0];

endmodule
`default_nettype wire

// File: tb/tb_arm_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_control_unit
//  Purpose  : Self-checking bench for arm_control_unit (ARM_CTRL_PERF_EN aware).
//  Revision : 1.0  initial release
// ============================================================================
module tb_arm_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [3:0]  ALUControl;
    logic        MemtoReg;
    logic        MemWrite;
    logic        PCSrc;
    logic [3:0]  Flags;
    logic        Undef;
`ifdef ARM_CTRL_PERF_EN
    logic [3:0]  ExecCount;
    logic [3:0]  SquashCount;
`endif

    arm_control_unit #(.COUNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Instr_i      (Instr),
        .ALUFlags_i   (ALUFlags),
        .RegSrc_o     (RegSrc),
        .RegWrite_o   (RegWrite),
        .ImmSrc_o     (ImmSrc),
        .ALUSrc_o     (ALUSrc),
        .ALUControl_o (ALUControl),
        .MemtoReg_o   (MemtoReg),
        .MemWrite_o   (MemWrite),
        .PCSrc_o      (PCSrc),
        .Flags_o      (Flags),
`ifdef ARM_CTRL_PERF_EN
        .ExecCount_o  (ExecCount),
        .SquashCount_o(SquashCount),
`endif
        .Undef_o      (Undef)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] regsrc;
        logic       rw;
        logic [1:0] imm;
        logic       alusrc;
        logic [3:0] ctl;
        logic       m2r;
        logic       mw;
        logic       pc;
        logic       und;
    } ctrl_t;

    typedef struct {
        logic [3:0]  fl;
        logic [31:0] ins;
        logic [3:0]  af;
        ctrl_t       c;
        logic [3:0]  nfl;
    } vec_t;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_ctrl(input string tag, input ctrl_t e);
        check({tag, " RegSrc"},     32'(RegSrc),     32'(e.regsrc));
        check({tag, " RegWrite"},   32'(RegWrite),   32'(e.rw));
        check({tag, " ImmSrc"},     32'(ImmSrc),     32'(e.imm));
        check({tag, " ALUSrc"},     32'(ALUSrc),     32'(e.alusrc));
        check({tag, " ALUControl"}, 32'(ALUControl), 32'(e.ctl));
        check({tag, " MemtoReg"},   32'(MemtoReg),   32'(e.m2r));
        check({tag, " MemWrite"},   32'(MemWrite),   32'(e.mw));
        check({tag, " PCSrc"},      32'(PCSrc),      32'(e.pc));
        check({tag, " Undef"},      32'(Undef),      32'(e.und));
    endtask

    function automatic vec_t mk(input logic [3:0] fl, input logic [31:0] ins, input logic [3:0] af,
                                input logic [1:0] rs, input logic rw, input logic [1:0] imm,
                                input logic as, input logic [3:0] ctl, input logic m2r,
                                input logic mw, input logic pc, input logic und,
                                input logic [3:0] nfl);
        vec_t v;
        v.fl = fl; v.ins = ins; v.af = af; v.nfl = nfl;
        v.c = '{regsrc: rs, rw: rw, imm: imm, alusrc: as, ctl: ctl,
                m2r: m2r, mw: mw, pc: pc, und: und};
        return v;
    endfunction

    // Reference model: condition table and instruction semantics by mnemonic.
    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;             4'h1: return !z;
            4'h2: return c;             4'h3: return !c;
            4'h4: return n;             4'h5: return !n;
            4'h6: return v;             4'h7: return !v;
            4'h8: return c && !z;       4'h9: return !c || z;
            4'hA: return n == v;        4'hB: return n != v;
            4'hC: return !z && n == v;  4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] af,
                                  output ctrl_t c, output logic [3:0] nfl);
        string mn;
        bit bad = 0, wr = 0, mwr = 0, br = 0, ok;
        c = '0;
        nfl = fl;
        mn = "";
        case (ins[27:26])
            2'b00: begin
                case (ins[24:21])
                    4'd0: mn = "AND";  4'd1: mn = "EOR";  4'd2: mn = "SUB";  4'd4: mn = "ADD";
                    4'd8: mn = "TST";  4'd10: mn = "CMP"; 4'd12: mn = "ORR"; 4'd13: mn = "MOV";
                    default: mn = "???";
                endcase
                c.alusrc = ins[25];
                if (mn == "???") bad = 1;
                else begin
                    wr = !(mn == "TST" || mn == "CMP");
                    if (!wr && !ins[20]) bad = 1;
                    if (mn == "ADD") c.ctl = 0;
                    else if (mn == "SUB" || mn == "CMP") c.ctl = 1;
                    else if (mn == "AND" || mn == "TST") c.ctl = 2;
                    else if (mn == "ORR") c.ctl = 3;
                    else if (mn == "EOR") c.ctl = 4;
                    else c.ctl = 5;
                end
            end
            2'b01: begin
                c.alusrc = 1; c.imm = 2'b01;
                c.ctl = ins[23] ? 4'd0 : 4'd1;
                if (ins[20]) begin wr = 1; c.m2r = 1; end
                else begin mwr = 1; c.regsrc = 2'b10; end
            end
            2'b10: begin
                c.imm = 2'b10; c.alusrc = 1; c.regsrc = 2'b01; br = 1;
                bad = ins[24];
            end
            default: bad = 1;
        endcase
        c.und = bad;
        ok = cond_holds(ins[31:28], fl) && !bad;
        c.rw = ok && wr;
        c.mw = ok && mwr;
        c.pc = ok && (br || (wr && ins[15:12] == 4'hF));
        if (ok && ins[27:26] == 2'b00 && ins[20]) begin
            if (mn == "ADD" || mn == "SUB" || mn == "CMP") nfl = af;
            else nfl = {af[3:2], fl[1:0]};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADDS R0,R0,#0 under AL loads all four flags from ALUFlags.
    task automatic set_flags(input logic [3:0] f);
        Instr = 32'hE2900000;
        ALUFlags = f;
        tick();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        ctrl_t      ec;
        logic [3:0] enfl;
        logic [3:0] mflags;
        logic [31:0] ins;
        logic [3:0] af;
        int mexec, msq;

        reset = 1'b1;
        Instr = $urandom;
        ALUFlags = 4'($urandom_range(0, 15));
        #12;
        check("reset Flags", 32'(Flags), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        //             fl    instr          af    rs    rw    imm   as    ctl   m2r   mw    pc    und   nfl
        vecs.push_back(mk(4'h0, 32'hE3A01005, 4'h0, 2'b00, 1'b1, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE2500001, 4'h4, 2'b00, 1'b1, 2'b00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4));
        vecs.push_back(mk(4'h4, 32'h0A000002, 4'h0, 2'b01, 1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4));
        vecs.push_back(mk(4'h4, 32'h1A000002, 4'h0, 2'b01, 1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4));
        vecs.push_back(mk(4'hB, 32'hE2110000, 4'h4, 2'b00, 1'b1, 2'b00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7));
        vecs.push_back(mk(4'h0, 32'hE5801004, 4'h0, 2'b10, 1'b0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE591F000, 4'h0, 2'b00, 1'b1, 2'b01, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hEB000000, 4'h0, 2'b01, 1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE3400000, 4'hF, 2'b00, 1'b0, 2'b00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE3500000, 4'h9, 2'b00, 1'b0, 2'b00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9));
        vecs.push_back(mk(4'h0, 32'hEC000000, 4'hF, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE0600000, 4'h0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        vecs.push_back(mk(4'h0, 32'hF3A01005, 4'h0, 2'b00, 1'b0, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hC3A01005, 4'h0, 2'b00, 1'b1, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hD3A01005, 4'h0, 2'b00, 1'b0, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE3A0F000, 4'h0, 2'b00, 1'b1, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'hE0900001, 4'hF, 2'b00, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
        vecs.push_back(mk(4'h3, 32'hE3900000, 4'h8, 2'b00, 1'b1, 2'b00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB));
        vecs.push_back(mk(4'h0, 32'h02300000, 4'hF, 2'b00, 1'b0, 2'b00, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h3, 32'hE3100000, 4'hC, 2'b00, 1'b0, 2'b00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
        vecs.push_back(mk(4'h0, 32'hE5101004, 4'h0, 2'b00, 1'b1, 2'b01, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h0, 32'h0A000002, 4'h4, 2'b01, 1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(4'h8, 32'hB3A01005, 4'h0, 2'b00, 1'b1, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8));
        vecs.push_back(mk(4'h9, 32'hA3A01005, 4'h0, 2'b00, 1'b1, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9));
        vecs.push_back(mk(4'h6, 32'h83A01005, 4'h0, 2'b00, 1'b0, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6));

        foreach (vecs[i]) begin
            set_flags(vecs[i].fl);
            check($sformatf("v%0d preset Flags", i), 32'(Flags), 32'(vecs[i].fl));
            Instr = vecs[i].ins;
            ALUFlags = vecs[i].af;
            #1;
            check_ctrl($sformatf("v%0d %h", i, vecs[i].ins), vecs[i].c);
            tick();
            check($sformatf("v%0d next Flags", i), 32'(Flags), 32'(vecs[i].nfl));
        end

        // Reset landing between edges while a flag-setting op is in flight.
        set_flags(4'hF);
        Instr = 32'hE2900000;
        ALUFlags = 4'h5;
        #2 reset = 1'b1;
        #1 check("async reset Flags", 32'(Flags), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("lost write Flags", 32'(Flags), 32'h0);

`ifdef ARM_CTRL_PERF_EN
        pulse_reset();
        check("perf reset Exec", 32'(ExecCount), 32'h0);
        check("perf reset Squash", 32'(SquashCount), 32'h0);
        Instr = 32'hE1A00000;
        for (int k = 0; k < 15; k++) tick();
        check("perf Exec 15", 32'(ExecCount), 32'd15);
        tick();
        check("perf Exec wrap", 32'(ExecCount), 32'h0);
        check("perf Squash idle", 32'(SquashCount), 32'h0);
        Instr = 32'hF1A00000;
        tick();
        check("perf Squash NV", 32'(SquashCount), 32'h1);
        check("perf Exec held", 32'(ExecCount), 32'h0);
`endif

        pulse_reset();
        mflags = 4'h0;
        mexec = 0;
        msq = 0;
        for (int k = 0; k < 300; k++) begin
            ins = $urandom;
            af = 4'($urandom_range(0, 15));
            if (k % 3 == 0) ins[31:28] = 4'hE;
            Instr = ins;
            ALUFlags = af;
            #1;
            model(ins, mflags, af, ec, enfl);
            check_ctrl($sformatf("rnd%0d %h", k, ins), ec);
            if (cond_holds(ins[31:28], mflags) && !ec.und) mexec++;
            else msq++;
            tick();
            mflags = enfl;
            check($sformatf("rnd%0d Flags", k), 32'(Flags), 32'(mflags));
`ifdef ARM_CTRL_PERF_EN
            check($sformatf("rnd%0d Exec", k), 32'(ExecCount), 32'(mexec % 16));
            check($sformatf("rnd%0d Squash", k), 32'(SquashCount), 32'(msq % 16));
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
